// File: rtl/mult_div_unit_if.sv
// Execute-stage handshake between the pipeline and the iterative RV32M multiply/divide unit.
// Signal suffixes are named from the unit's point of view.
interface mult_div_unit_if #(
   parameter int XLEN = 32
);

   logic            start_i;
   logic [2:0]      op_i;
   logic [XLEN-1:0] operand_a_i;
   logic [XLEN-1:0] operand_b_i;
   logic            flush_i;
   logic            hold_i;
   logic            stall_req_o;
   logic [XLEN-1:0] result_o;
   logic            result_valid_o;
   logic            busy_o;

   modport master (
      output start_i, op_i, operand_a_i, operand_b_i, flush_i, hold_i,
      input  stall_req_o, result_o, result_valid_o, busy_o
   );

   modport slave (
      input  start_i, op_i, operand_a_i, operand_b_i, flush_i, hold_i,
      output stall_req_o, result_o, result_valid_o, busy_o
   );

endinterface

// File: rtl/mult_div_unit.sv
// Iterative RV32M multiply/divide unit beside the ALU: a registered multiply over MUL_CYCLES
// wait cycles and a 32-cycle restoring divider, stalling Execute while it works.
module mult_div_unit #(
   parameter int XLEN       = 32,
   parameter int MUL_CYCLES = 1
) (
   input logic            clk_i,
   input logic            rst_i,
   mult_div_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

   localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state_q, state_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [1:0]      op_q, op_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            negQ_q, negQ_d;
   logic            negR_q, negR_d;
   logic            stallReq;

   logic              aSigned, bSigned;
   logic [2*XLEN-1:0] aExt, bExt, product;
   logic [XLEN-1:0]   mulResult;

   logic [XLEN:0]   remShift;
   logic            divGeq;
   logic [XLEN-1:0] remNext, quoNext, divResult;

   logic            opSigned, divByZero, divOverflow;
   logic [XLEN-1:0] absA, absB;

   // Sign-extending to the full product width makes the low 2*XLEN bits of a plain multiply
   // equal the exact signed/unsigned product for every operand signedness mix.
   always_comb begin
      aSigned   = (op_q != 2'b11);
      bSigned   = !op_q[1];
      aExt      = {{XLEN{aSigned & a_q[XLEN-1]}}, a_q};
      bExt      = {{XLEN{bSigned & b_q[XLEN-1]}}, b_q};
      product   = aExt * bExt;
      mulResult = (op_q == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
   end

   // One restoring step: the dividend shifts out of a_q while quotient bits shift in behind it.
   always_comb begin
      remShift  = {rem_q, a_q[XLEN-1]};
      divGeq    = (remShift >= {1'b0, b_q});
      remNext   = divGeq ? (remShift[XLEN-1:0] - b_q) : remShift[XLEN-1:0];
      quoNext   = {a_q[XLEN-2:0], divGeq};
      divResult = op_q[1] ? (negR_q ? -remNext : remNext)
                          : (negQ_q ? -quoNext : quoNext);
   end

   always_comb begin
      opSigned    = !bus.op_i[0];
      divByZero   = (bus.operand_b_i == '0);
      divOverflow = opSigned && (bus.operand_a_i == MinInt) && (bus.operand_b_i == '1);
      absA        = (opSigned && bus.operand_a_i[XLEN-1]) ? -bus.operand_a_i : bus.operand_a_i;
      absB        = (opSigned && bus.operand_b_i[XLEN-1]) ? -bus.operand_b_i : bus.operand_b_i;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      rem_d    = rem_q;
      negQ_d   = negQ_q;
      negR_d   = negR_q;
      result_d = result_q;
      stallReq = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               stallReq = 1'b1;
               op_d     = bus.op_i[1:0];
               if (!bus.op_i[2]) begin
                  a_d     = bus.operand_a_i;
                  b_d     = bus.operand_b_i;
                  cnt_d   = 5'(MUL_CYCLES - 1);
                  state_d = MUL;
               end else if (divByZero) begin
                  result_d = bus.op_i[1] ? bus.operand_a_i : '1;
                  state_d  = DONE;
               end else if (divOverflow) begin
                  result_d = bus.op_i[1] ? '0 : MinInt;
                  state_d  = DONE;
               end else begin
                  a_d     = absA;
                  b_d     = absB;
                  rem_d   = '0;
                  negQ_d  = opSigned && (bus.operand_a_i[XLEN-1] ^ bus.operand_b_i[XLEN-1]);
                  negR_d  = opSigned && bus.operand_a_i[XLEN-1];
                  cnt_d   = 5'(XLEN - 1);
                  state_d = DIV;
               end
            end
         end
         MUL: begin
            stallReq = 1'b1;
            cnt_d    = cnt_q - 5'd1;
            if (cnt_q == '0) begin
               result_d = mulResult;
               cnt_d    = '0;
               state_d  = DONE;
            end
         end
         DIV: begin
            stallReq = 1'b1;
            a_d      = quoNext;
            rem_d    = remNext;
            cnt_d    = cnt_q - 5'd1;
            if (cnt_q == '0) begin
               result_d = divResult;
               cnt_d    = '0;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (!bus.hold_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A killed instruction never publishes a result, even if it would have completed now.
      if (bus.flush_i) begin
         state_d  = IDLE;
         result_d = result_q;
         stallReq = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         rem_q    <= '0;
         negQ_q   <= 1'b0;
         negR_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rem_q    <= rem_d;
         negQ_q   <= negQ_d;
         negR_q   <= negR_d;
         result_q <= result_d;
      end
   end

   assign bus.stall_req_o    = stallReq;
   assign bus.result_o       = result_q;
   assign bus.result_valid_o = (state_q == DONE) && !bus.flush_i;
   assign bus.busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: a latency/result model built from RV32M arithmetic is compared
// against the unit every cycle, with directed literal cases and randomized operations.
module tb_mult_div_unit;

   localparam int          MulCycles = 1;
   localparam int          DivLat    = 33;
   localparam logic [31:0] MinInt    = 32'h80000000;
   localparam logic [2:0]  OpMul = 3'd0, OpMulh = 3'd1, OpMulhsu = 3'd2, OpMulhu = 3'd3;
   localparam logic [2:0]  OpDiv = 3'd4, OpDivu = 3'd5, OpRem = 3'd6, OpRemu = 3'd7;

   logic        clk = 1'b0;
   logic        rstIn, startIn, flushIn, holdIn;
   logic [2:0]  opIn;
   logic [31:0] aIn, bIn;
   int          checks = 0;
   int          errors = 0;

   logic        mActive, mDone, expIdle;
   int          mLeft;
   logic [31:0] mPending, mLast;

   always #5 clk = ~clk;

   mult_div_unit_if #(.XLEN(32)) bus ();

   assign bus.start_i     = startIn;
   assign bus.op_i        = opIn;
   assign bus.operand_a_i = aIn;
   assign bus.operand_b_i = bIn;
   assign bus.flush_i     = flushIn;
   assign bus.hold_i      = holdIn;

   mult_div_unit #(.XLEN(32), .MUL_CYCLES(MulCycles)) dut (
      .clk_i (clk),
      .rst_i (rstIn),
      .bus   (bus)
   );

   function automatic logic [31:0] refResult(logic [2:0] op, logic [31:0] a, logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      int          sdA, sdB;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      sdA = a;
      sdB = b;
      case (op)
         OpMul:    begin p = sa * sb; return p[31:0];  end
         OpMulh:   begin p = sa * sb; return p[63:32]; end
         OpMulhsu: begin p = sa * ub; return p[63:32]; end
         OpMulhu:  begin p = ua * ub; return p[63:32]; end
         OpDiv: begin
            if (b == 32'd0) return 32'hFFFFFFFF;
            if (a == MinInt && b == 32'hFFFFFFFF) return MinInt;
            return sdA / sdB;
         end
         OpDivu: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
         OpRem: begin
            if (b == 32'd0) return a;
            if (a == MinInt && b == 32'hFFFFFFFF) return 32'd0;
            return sdA % sdB;
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic int refLatency(logic [2:0] op, logic [31:0] a, logic [31:0] b);
      if (!op[2]) return MulCycles + 1;
      if (b == 32'd0) return 1;
      if (!op[0] && a == MinInt && b == 32'hFFFFFFFF) return 1;
      return DivLat;
   endfunction

   function automatic logic [31:0] randOperand();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return MinInt;
         2:       return 32'hFFFFFFFF;
         3:       return 32'($urandom_range(0, 20));
         4:       return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Timeline model: an accepted op is busy for its latency, then done until hold drops.
   always @(posedge clk) begin
      if (rstIn) begin
         mActive <= 1'b0;
         mDone   <= 1'b0;
         mLast   <= 32'd0;
         mLeft   <= 0;
      end else if (flushIn) begin
         mActive <= 1'b0;
         mDone   <= 1'b0;
      end else if (mDone) begin
         if (!holdIn) mDone <= 1'b0;
      end else if (mActive) begin
         if (mLeft == 1) begin
            mActive <= 1'b0;
            mDone   <= 1'b1;
            mLast   <= mPending;
         end
         mLeft <= mLeft - 1;
      end else if (startIn) begin
         if (refLatency(opIn, aIn, bIn) == 1) begin
            mDone <= 1'b1;
            mLast <= refResult(opIn, aIn, bIn);
         end else begin
            mActive  <= 1'b1;
            mLeft    <= refLatency(opIn, aIn, bIn) - 1;
            mPending <= refResult(opIn, aIn, bIn);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rstIn) begin
            expIdle = !mActive && !mDone;
            checkOutput("stall_req_o", 32'(bus.stall_req_o),
                        32'(!flushIn && (mActive || (expIdle && startIn))));
            checkOutput("result_valid_o", 32'(bus.result_valid_o), 32'(mDone && !flushIn));
            checkOutput("busy_o", 32'(bus.busy_o), 32'(mActive || mDone));
            checkOutput("result_o", bus.result_o, mLast);
         end
      end
   end

   // Called at a negedge; returns at the negedge of the last DONE cycle with start still high.
   task automatic applyStimulus(logic [2:0] op, logic [31:0] a, logic [31:0] b,
                                logic [31:0] expRes, int expLat, int holdCycles,
                                bit backToBack, bit scramble);
      int n;
      bit got;
      opIn    = op;
      aIn     = a;
      bIn     = b;
      startIn = 1'b1;
      if (backToBack) @(posedge clk);
      n   = 0;
      got = 1'b0;
      while (n < 100 && !got) begin
         @(posedge clk);
         #1;
         n++;
         got = bus.result_valid_o;
         if (scramble && n == 1) begin
            aIn  = $urandom;
            bIn  = $urandom;
            opIn = 3'($urandom);
         end
      end
      checkOutput("valid_seen", 32'(got), 32'd1);
      checkOutput("latency", 32'(n), 32'(expLat));
      checkOutput("result", bus.result_o, expRes);
      if (holdCycles > 0) begin
         @(negedge clk);
         holdIn = 1'b1;
         repeat (holdCycles) @(negedge clk);
         checkOutput("held_result", bus.result_o, expRes);
         holdIn = 1'b0;
      end else begin
         @(negedge clk);
      end
   endtask

   task automatic idleGap(int n);
      startIn = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic flushOp(logic [2:0] op, logic [31:0] a, logic [31:0] b, int offset);
      opIn    = op;
      aIn     = a;
      bIn     = b;
      startIn = 1'b1;
      repeat (offset) @(negedge clk);
      flushIn = 1'b1;
      #1;
      checkOutput("flush_stall", 32'(bus.stall_req_o), 32'd0);
      checkOutput("flush_valid", 32'(bus.result_valid_o), 32'd0);
      @(negedge clk);
      flushIn = 1'b0;
      startIn = 1'b0;
      #1;
      checkOutput("after_flush_busy", 32'(bus.busy_o), 32'd0);
   endtask

   task automatic resetDuring(logic [2:0] op, logic [31:0] a, logic [31:0] b,
                              int offset, bit withHold);
      opIn    = op;
      aIn     = a;
      bIn     = b;
      startIn = 1'b1;
      holdIn  = withHold;
      repeat (offset) @(negedge clk);
      rstIn   = 1'b1;
      startIn = 1'b0;
      holdIn  = 1'b0;
      @(negedge clk);
      rstIn = 1'b0;
      #1;
      checkOutput("rst_stall", 32'(bus.stall_req_o), 32'd0);
      checkOutput("rst_valid", 32'(bus.result_valid_o), 32'd0);
      checkOutput("rst_busy", 32'(bus.busy_o), 32'd0);
      checkOutput("rst_result", bus.result_o, 32'd0);
      @(negedge clk);
   endtask

   initial begin
      logic [2:0]  rOp;
      logic [31:0] rA, rB;
      bit          pendingDone;

      rstIn   = 1'b1;
      startIn = 1'b0;
      flushIn = 1'b0;
      holdIn  = 1'b0;
      opIn    = 3'd0;
      aIn     = 32'd0;
      bIn     = 32'd0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("init_stall", 32'(bus.stall_req_o), 32'd0);
      checkOutput("init_valid", 32'(bus.result_valid_o), 32'd0);
      checkOutput("init_busy", 32'(bus.busy_o), 32'd0);
      checkOutput("init_result", bus.result_o, 32'd0);
      rstIn = 1'b0;
      @(negedge clk);

      checkOutput("pin_mul", refResult(OpMul, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
      checkOutput("pin_mulhsu", refResult(OpMulhsu, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
      checkOutput("pin_div", refResult(OpDiv, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
      checkOutput("pin_rem", refResult(OpRem, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);

      $display("[TB] directed multiply cases");
      applyStimulus(OpMul, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MulCycles + 1, 0, 1'b0, 1'b1);
      applyStimulus(OpMulhu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MulCycles + 1, 0, 1'b1, 1'b0);
      applyStimulus(OpMulhsu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MulCycles + 1, 0, 1'b1, 1'b0);
      applyStimulus(OpMulh, MinInt, MinInt, 32'h40000000, MulCycles + 1, 3, 1'b1, 1'b0);
      idleGap(1);

      $display("[TB] directed divide cases");
      applyStimulus(OpDiv, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, DivLat, 0, 1'b0, 1'b1);
      applyStimulus(OpRem, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, DivLat, 0, 1'b1, 1'b0);
      applyStimulus(OpDivu, 32'd100, 32'd7, 32'd14, DivLat, 0, 1'b1, 1'b0);
      applyStimulus(OpRemu, 32'd100, 32'd7, 32'd2, DivLat, 0, 1'b1, 1'b0);
      applyStimulus(OpDivu, 32'h1234, 32'd0, 32'hFFFFFFFF, 1, 0, 1'b1, 1'b0);
      applyStimulus(OpRem, 32'h1234, 32'd0, 32'h1234, 1, 0, 1'b1, 1'b0);
      applyStimulus(OpDiv, MinInt, 32'hFFFFFFFF, MinInt, 1, 0, 1'b1, 1'b0);
      applyStimulus(OpRem, MinInt, 32'hFFFFFFFF, 32'd0, 1, 2, 1'b1, 1'b0);
      idleGap(1);

      $display("[TB] flush and reset cases");
      flushOp(OpDiv, 32'd1000, 32'd7, 10);
      applyStimulus(OpDivu, 32'd9, 32'd3, 32'd3, DivLat, 0, 1'b0, 1'b0);
      idleGap(1);
      resetDuring(OpMul, 32'd5, 32'd6, 5, 1'b1);
      resetDuring(OpDivu, 32'd50, 32'd3, 12, 1'b0);

      $display("[TB] randomized operations");
      pendingDone = 1'b0;
      for (int i = 0; i < 60; i++) begin
         rOp = 3'($urandom_range(0, 7));
         rA  = randOperand();
         rB  = randOperand();
         if ($urandom_range(0, 9) == 0) begin
            if (pendingDone) idleGap(1);
            flushOp(rOp, rA, rB, $urandom_range(0, 40));
            pendingDone = 1'b0;
         end else if (pendingDone && $urandom_range(0, 1) == 1) begin
            applyStimulus(rOp, rA, rB, refResult(rOp, rA, rB), refLatency(rOp, rA, rB),
                          $urandom_range(0, 2), 1'b1, 1'b1);
         end else begin
            if (pendingDone) idleGap($urandom_range(1, 2));
            applyStimulus(rOp, rA, rB, refResult(rOp, rA, rB), refLatency(rOp, rA, rB),
                          $urandom_range(0, 2), 1'b0, 1'b1);
            pendingDone = 1'b1;
         end
      end
      idleGap(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative RV32M multiply/divide unit that sits in the Execute stage beside the ALU. It is the requesting end of the Execute stall handshake: it raises `stall_req_o`, which feeds the hazard unit's `exec_stall_req_i`, to hold Fetch, Decode and Execute while it computes. It drops the request on the cycle its result is valid, so the instruction can retire through EX/MEM.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `MUL_CYCLES`, default 1: number of wait cycles in the MUL state, range 1..4.
- `clk_i` in, 1: core clock.
- `rst_i` in, 1: reset. One clock; reset is synchronous and active-high.
- `start_i` in, 1: a valid M-extension instruction is in Execute. Held high while the instruction sits in ID/EX.
- `op_i` in, 3: funct3. MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
- `operand_a_i` in, XLEN: rs1 value after forwarding.
- `operand_b_i` in, XLEN: rs2 value after forwarding.
- `flush_i` in, 1: kill the Execute instruction. Synchronous abort.
- `hold_i` in, 1: a later stage is stalled (memory wait), so Execute cannot advance.
- `stall_req_o` out, 1: stall request to the hazard unit.
- `result_o` out, XLEN: computed result.
- `result_valid_o` out, 1: `result_o` is valid for the instruction in Execute.
- `busy_o` out, 1: state is not IDLE.

## Operation
- States are IDLE, MUL, DIV and DONE.
- **Reset:** state=IDLE, `result_o`=0, counter=0, all internal operand and accumulator registers=0. `stall_req_o`, `result_valid_o` and `busy_o` are 0.
- **`stall_req_o`:** equals (IDLE && `start_i` && !`flush_i`) || MUL || DIV, with `flush_i` forcing it to 0. It is combinational on `start_i` in IDLE so the hazard unit stalls in the first cycle. It is 0 in DONE.
- **IDLE, `start_i` high, `flush_i` low:**
  - Capture `op_i` and both operands.
  - op[2]=0 goes to MUL with counter=`MUL_CYCLES`-1.
  - op[2]=1 with divisor=0 goes to DONE. Quotient is all ones; remainder is the dividend.
  - DIV/REM with dividend=0x80000000 and divisor=0xFFFFFFFF goes to DONE. Quotient is 0x80000000; remainder is 0.
  - Any other divide goes to DIV with counter=31.
  - `hold_i` does not block starting.
- **MUL:**
  - Form the 33x33 signed product of sign- or zero-extended operands. a is signed for MUL, MULH and MULHSU. b is signed for MUL and MULH.
  - Register the 64-bit product.
  - Decrement the counter each cycle and go to DONE after the cycle in which counter=0.
  - MUL returns the low 32 bits. All other multiply ops return the high 32 bits.
- **DIV:**
  - Restoring radix-2 division on magnitudes; the signed ops take the absolute value of each operand at capture.
  - One quotient bit per cycle, 32 cycles. Counter 31 down to 0, then go to DONE.
  - Signed quotient is negated if the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - DIV/DIVU return the quotient. REM/REMU return the remainder.
- **DONE:**
  - `result_valid_o`=1 and `result_o` is final and held.
  - `hold_i`=1: stay in DONE and do not restart, even though `start_i` is still high.
  - `hold_i`=0: go to IDLE.
- **`flush_i` in any state:** next state is IDLE, with no `result_valid_o` in the flush cycle or after. `flush_i` has priority over `start_i`, `hold_i` and completion.
- **`rst_i`:** has priority over everything. Reset mid-operation returns the unit to IDLE in the next cycle.
- **`result_o`:** holds its last value in IDLE. It is updated only on the entry into DONE.

## Timing
- Let T be the cycle `start_i` is first seen in IDLE.
- **Multiply:** `stall_req_o`=1 during T..T+`MUL_CYCLES`. DONE and valid at T+`MUL_CYCLES`+1. Default residency in Execute is 3 cycles.
- **Divide:** `stall_req_o`=1 during T..T+32. DONE at T+33, so residency is 34 cycles.
- **Special-case divide:** `stall_req_o`=1 at T only. DONE at T+1.
- **Back-to-back instructions:** the instruction leaves Execute at the end of the DONE cycle. The next M-op presents `start_i` in the following cycle with the unit in IDLE, so there are no lost cycles beyond the IDLE capture.
- **Operand stability:** operands are sampled only at T. Changes to the inputs afterwards are ignored.

## Test plan
- MUL with a=7, b=0xFFFFFFFD (−3) -> `stall_req_o` high 2 cycles, then `result_o`=0xFFFFFFEB with `result_valid_o`=1 at T+2.
- MULHU with a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU with a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MULH with a=b=0x80000000 -> 0x40000000.
- DIV a=0xFFFFFFF9 (−7), b=2 -> 0xFFFFFFFD at T+33. REM on the same operands -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU -> 2.
- DIVU a=0x1234, b=0 -> 0xFFFFFFFF at T+1. REM a=0x1234, b=0 -> 0x1234. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM on the same operands -> 0.
- `flush_i` at T+10 of a divide -> IDLE at T+11, `stall_req_o`=0 in the flush cycle, no valid pulse. A new DIVU 9/3 then yields 3 at its T'+33.
- `hold_i` high for 3 cycles in DONE -> `result_valid_o` and `result_o` stable, no restart; IDLE the cycle after `hold_i` falls. Separately, `rst_i` at T+5 of a multiply -> IDLE and all outputs 0 next cycle.
